// File: rtl/delay_btn_ctrl.sv
// Delay-tap button controller: sync, debounce, tap counters and send FSM.
// Optional DELAY_DEC_EN adds inverse_sw so presses decrement taps instead.
module delay_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int TAP_W           = 5
) (
  input  logic               clk_slow,
  input  logic               slow_rst,
  input  logic [8:0]         btn_raw,
  input  logic               send_enable_button,
  input  logic               send_stop_button,
`ifdef DELAY_DEC_EN
  input  logic               inverse_sw,
`endif
  output logic [9*TAP_W-1:0] taps,
  output logic               tap_load,
  output logic [8:0]         tap_sel,
  output logic               send_en,
  output logic [3:0]         led_out
);

  localparam int NB = 11;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    lvl_q, lvl_d;
  logic [NB-1:0]    press_q, press_d;
  logic [CW-1:0]    cnt_q [NB];
  logic [CW-1:0]    cnt_d [NB];

  logic [9*TAP_W-1:0] taps_q, taps_d;
  logic               tap_load_q, tap_load_d;
  logic [8:0]         tap_sel_q, tap_sel_d;
  logic [2:0]         col_q, col_d;
  logic               dec;

  state_t state_q;
  logic   send_en_q;
  logic   en_p, stop_p;

  assign raw = {send_stop_button, send_enable_button, btn_raw};

`ifdef DELAY_DEC_EN
  logic inv_s1_q, inv_s2_q;

  always_ff @(posedge clk_slow or negedge slow_rst) begin
    if (!slow_rst) begin
      inv_s1_q <= 1'b0;
      inv_s2_q <= 1'b0;
    end else begin
      inv_s1_q <= inverse_sw;
      inv_s2_q <= inv_s1_q;
    end
  end

  assign dec = inv_s2_q;
`else
  assign dec = 1'b0;
`endif

  // Count cycles the synced level differs from the accepted one.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) lvl_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    press_d = lvl_d & ~lvl_q;
  end

  always_comb begin
    taps_d     = taps_q;
    tap_load_d = |press_q[8:0];
    tap_sel_d  = press_q[8:0];
    col_d      = col_q;
    for (int k = 8; k >= 0; k--) begin
      if (press_q[k]) begin
        if (dec)
          taps_d[k*TAP_W +: TAP_W] = taps_q[k*TAP_W +: TAP_W] - 1'b1;
        else
          taps_d[k*TAP_W +: TAP_W] = taps_q[k*TAP_W +: TAP_W] + 1'b1;
        col_d = 3'(1 << (k % 3));
      end
    end
  end

  always_ff @(posedge clk_slow or negedge slow_rst) begin
    if (!slow_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      press_q    <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      taps_q     <= '0;
      tap_load_q <= 1'b0;
      tap_sel_q  <= '0;
      col_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      press_q    <= press_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      taps_q     <= taps_d;
      tap_load_q <= tap_load_d;
      tap_sel_q  <= tap_sel_d;
      col_q      <= col_d;
    end
  end

  assign en_p   = press_q[9];
  assign stop_p = press_q[10];

  // Stop has priority when both presses land together.
  always_ff @(posedge clk_slow or negedge slow_rst) begin
    if (!slow_rst) begin
      state_q   <= IDLE;
      send_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en_p && !stop_p) begin
            state_q   <= RUN;
            send_en_q <= 1'b1;
          end
        end
        RUN: begin
          if (stop_p) begin
            state_q   <= IDLE;
            send_en_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          send_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign taps     = taps_q;
  assign tap_load = tap_load_q;
  assign tap_sel  = tap_sel_q;
  assign send_en  = send_en_q;
  assign led_out  = {col_q, send_en_q};

endmodule

// File: doc/delay_btn_ctrl.md
DELAY_BTN_CTRL -- requirements
Module: delay_btn_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, meaning consecutive stable slow-clock cycles required before a button level is accepted.
REQ-002 Parameter TAP_W, default 5, meaning width of each delay-tap count (range 0..2^TAP_W-1).
REQ-003 clk_slow  input  1  slow fabric clock, the divided-down domain of clk_x10.
REQ-004 slow_rst  input  1  reset, asynchronous, active-low.
REQ-005 btn_raw  input  9  raw delay buttons: [0..2] r/g/b whole, [3..5] r/g/b rising, [6..8] r/g/b falling.
REQ-006 send_enable_button, send_stop_button  input  1 each  raw transmit start/stop buttons.
REQ-007 taps  output  9*TAP_W  packed tap counts, slice k = taps[k*TAP_W +: TAP_W], same index order as btn_raw.
REQ-008 tap_load  output  1  one-cycle strobe: taps changed, downstream delay lines reload.
REQ-009 tap_sel  output  9  one-hot or multi-hot mask of slices changed in the strobed update.
REQ-010 send_en  output  1  level, high while the transmit pattern generator runs.
REQ-011 led_out  output  4  status: [0]=send_en, [1]=red, [2]=green, [3]=blue slice last adjusted.

Function
REQ-012 Each of the 11 button inputs SHALL pass a 2-flop synchronizer, then a per-button debouncer.
REQ-013 Debouncer SHALL update its accepted level only after DEBOUNCE_CYCLES consecutive cycles of an unchanged synchronized level; any change restarts the count from 0.
REQ-014 A 0->1 transition of the accepted level SHALL produce exactly one press pulse of one cycle; holding a button SHALL produce no further pulses.
REQ-015 A press on delay button k SHALL add 1 to slice k; 2^TAP_W-1 SHALL wrap to 0.
REQ-016 Tap update SHALL occur on the cycle after the press pulse; tap_load and tap_sel SHALL assert in that same cycle, for that cycle only.
REQ-017 Simultaneous presses SHALL update all affected slices in the same cycle with a single tap_load and tap_sel set for every affected slice.
REQ-018 led_out[3:1] SHALL show the colour of the lowest-index slice in the latest update and hold until the next update.
REQ-019 Send FSM states: IDLE, RUN. IDLE->RUN on enable press; RUN->IDLE on stop press; send_en=1 only in RUN.
REQ-020 Enable and stop pressed in the same cycle: stop SHALL win (IDLE, or RUN->IDLE).
REQ-021 Enable press in RUN, stop press in IDLE: no state change.
REQ-022 Tap changes SHALL be accepted in both IDLE and RUN.

Reset
REQ-023 On slow_rst=0: all taps=0, tap_load=0, tap_sel=0, send_en=0, led_out=0, FSM=IDLE, synchronizers and accepted levels=0, debounce counters=0.
REQ-024 Reset release SHALL allow press detection from the first clk_slow edge; a button held through reset SHALL register one press after DEBOUNCE_CYCLES+3 cycles.
REQ-025 Reset asserted mid-debounce or in RUN SHALL discard pending presses and return to REQ-023 values.

Configuration
REQ-026 Macro DELAY_DEC_EN: when defined, input inverse_sw (1 bit, synchronized) SHALL exist; inverse_sw=1 makes presses subtract 1 with 0 wrapping to 2^TAP_W-1; undefined: port absent, presses always add 1.

Verification
REQ-027 DEBOUNCE_CYCLES=4; btn_raw[0] high 20 cycles -> exactly one tap_load, taps slice0=1, tap_sel=9'h001, led_out=4'b0010.
REQ-028 btn_raw[4] glitch high 3 cycles then low -> no tap_load, taps unchanged.
REQ-029 32 presses on btn_raw[8] with TAP_W=5 -> slice8 runs 1..31 then 0, 32 tap_load pulses.
REQ-030 btn_raw[1] and btn_raw[5] rise same cycle -> single tap_load, tap_sel=9'h022, led_out[3:1]=3'b010.
REQ-031 Enable press -> send_en=1; enable+stop same cycle -> send_en=0; slow_rst pulsed low in RUN -> send_en=0, all taps 0.
REQ-032 With DELAY_DEC_EN, inverse_sw=1, press btn_raw[2] from reset -> slice2=31.
